imm_extend_sequencer: RTL and testbench
=======================================

IMM_EXTEND_SEQUENCER -- requirements
Module: imm_extend_sequencer

Interface
REQ-001 The block SHALL take parameter OUTPUTSize, default 32, giving the width of IMM; legal range 20..64.
REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port FLUSH, input, 1, synchronous discard of pending prefix and output word.
REQ-005 The block SHALL have port IN_VALID, input, 1, INST holds a valid instruction word.
REQ-006 The block SHALL have port IN_READY, output, 1, block accepts INST this cycle.
REQ-007 The block SHALL have port INST, input, 16: [15:12] opcode, [8] U (1 = zero-extend), [7:0] short immediate; opcode 4'hF = prefix, payload [11:0].
REQ-008 The block SHALL have port OUT_VALID, output, 1, IMM/OPCODE hold a result.
REQ-009 The block SHALL have port OUT_READY, input, 1, consumer takes the result this cycle.
REQ-010 The block SHALL have port IMM, output, OUTPUTSize, extended immediate.
REQ-011 The block SHALL have port OPCODE, output, 4, opcode of the instruction that produced IMM.
REQ-012 The block SHALL have port ERR, output, 1, sticky prefix-error flag.

Function
REQ-013 Handshakes SHALL complete only when VALID and READY are both high on a rising edge.
REQ-014 IN_READY SHALL equal (!OUT_VALID || OUT_READY) && !FLUSH, combinationally.
REQ-015 The FSM SHALL have two states: IDLE (no prefix held) and PREFIXED (12-bit payload held).
REQ-016 In IDLE, an accepted prefix word SHALL store INST[11:0], move to PREFIXED and produce no output.
REQ-017 In IDLE, an accepted non-prefix word SHALL load IMM with INST[7:0] extended to OUTPUTSize (sign bit 7 when U=0, zeros when U=1), load OPCODE = INST[15:12] and set OUTPUT_VALID next cycle, i.e. 1-cycle latency.
REQ-018 In PREFIXED, an accepted non-prefix word SHALL form the 20-bit field {payload, INST[7:0]}, extend it (sign bit 19 when U=0, zeros when U=1), register it as in REQ-017 and return to IDLE.
REQ-019 In PREFIXED, an accepted prefix word SHALL replace the payload, remain in PREFIXED and raise the error condition.
REQ-020 An output handshake without a simultaneous new result SHALL clear OUT_VALID next cycle.
REQ-021 An output handshake and an input result in the same cycle SHALL load the new result with OUT_VALID held high, giving full throughput.
REQ-022 While OUT_VALID=1 and OUT_READY=0, IMM and OPCODE SHALL stay stable.
REQ-023 FLUSH SHALL clear OUT_VALID, return the FSM to IDLE and leave ERR unchanged; INST is ignored that cycle.
REQ-024 RESET SHALL take priority over FLUSH; FLUSH SHALL take priority over all handshakes.

Reset
REQ-025 On RESET the FSM SHALL enter IDLE and the block SHALL clear OUT_VALID, IMM, OPCODE, ERR and the stored payload to 0.
REQ-026 With RESET high, IN_READY SHALL still follow REQ-014, but no word SHALL be accepted.
REQ-027 A RESET asserted mid-sequence, with a prefix held, SHALL discard the prefix; the next non-prefix word SHALL use the short form.

Configuration
REQ-028 With macro IMMSEQ_PREFIX_ERR_EN defined, ERR SHALL set on the cycle after a REQ-019 event and stay high until RESET.
REQ-029 Without IMMSEQ_PREFIX_ERR_EN, ERR SHALL be tied to 0 and no error register SHALL exist.
REQ-030 Datapath behaviour SHALL be identical with and without the macro.

Verification
REQ-031 The bench SHALL cover: INST=16'h1280, U=0 -> one cycle later OUT_VALID=1, IMM=32'hFFFFFF80, OPCODE=4'h1.
REQ-032 The bench SHALL cover: INST=16'h1380, U=1 -> IMM=32'h00000080.
REQ-033 The bench SHALL cover: 16'hF800 then 16'h2005 -> one output, IMM=32'hFFF80005; with 16'h2105 instead -> 32'h00080005.
REQ-034 The bench SHALL cover: 16'hF001, 16'hF002, 16'h1003 -> IMM=32'h00000203; ERR=1 with the macro, ERR=0 without.
REQ-035 The bench SHALL cover: OUT_READY held 0 with a result pending -> IN_READY=0 and IMM stable; then OUT_READY=1 with IN_VALID=1 on every cycle -> one result per cycle and no word dropped.
REQ-036 The bench SHALL cover: 16'hF800 accepted, then FLUSH (or RESET), then 16'h1280 -> IMM=32'hFFFFFF80, with the prefix discarded.

Source files
------------

// File: rtl/imm_extend_sequencer.sv
// -----------------------------------------------------------------------------
// imm_extend_sequencer
//
// Builds extended immediates from a 16-bit instruction stream. A prefix word
// (opcode 4'hF) carries 12 high-order bits that are combined with the 8-bit
// short immediate of the following instruction into a 20-bit field. Without a
// prefix only the 8-bit short immediate is used. The field is sign- or
// zero-extended (U bit, INST[8]) to OUTPUTSize bits and presented on a
// valid/ready output with one cycle of latency and full throughput.
//
// Parameters
//   OUTPUTSize  width of IMM, legal range 20..64 (default 32)
//
// Configuration macro
//   IMMSEQ_PREFIX_ERR_EN  when defined, ERR is a sticky flag set after a prefix
//                         follows a prefix; otherwise ERR is tied low.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   synchronous active-high reset
//   FLUSH      in   synchronous discard of held prefix and pending output
//   IN_VALID   in   INST holds a valid instruction word
//   IN_READY   out  block accepts INST this cycle
//   INST       in   [15:12] opcode, [8] U (1 = zero-extend), [7:0] short imm;
//                   opcode 4'hF is a prefix with payload [11:0]
//   OUT_VALID  out  IMM/OPCODE hold a result
//   OUT_READY  in   consumer takes the result this cycle
//   IMM        out  extended immediate
//   OPCODE     out  opcode of the instruction that produced IMM
//   ERR        out  sticky prefix-error flag
// -----------------------------------------------------------------------------
module imm_extend_sequencer #(
  parameter int OUTPUTSize = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [15:0]           INST,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [OUTPUTSize-1:0] IMM,
  output logic [3:0]            OPCODE,
  output logic                  ERR
);

  typedef enum logic {
    IDLE     = 1'b0,
    PREFIXED = 1'b1
  } state_t;

  localparam logic [3:0] PREFIX_OP = 4'hF;

  state_t                  state;
  logic [11:0]             payload;

  logic                    accept;
  logic                    is_prefix;
  logic                    sign_bit;
  logic [19:0]             field;
  logic [OUTPUTSize-1:0]   next_imm;

  // Input is taken when the output slot is free or draining this cycle.
  assign IN_READY  = (!OUT_VALID || OUT_READY) && !FLUSH;
  assign accept    = IN_VALID && IN_READY;
  assign is_prefix = (INST[15:12] == PREFIX_OP);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sign_bit = 1'b0;
    field    = '0;
    next_imm = '0;
    if (state == PREFIXED) begin
      sign_bit = payload[11] & ~INST[8];
      field    = {payload, INST[7:0]};
    end else begin
      sign_bit = INST[7] & ~INST[8];
      field    = {{12{sign_bit}}, INST[7:0]};
    end
    // Fill with the sign, then overlay the 20-bit field; this stays legal
    // when OUTPUTSize is exactly 20.
    next_imm        = {OUTPUTSize{sign_bit}};
    next_imm[19:0]  = field;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      payload   <= '0;
      OUT_VALID <= 1'b0;
      IMM       <= '0;
      OPCODE    <= '0;
    end else if (FLUSH) begin
      state     <= IDLE;
      OUT_VALID <= 1'b0;
    end else begin
      // A consumed result drops valid unless a new one lands below.
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (accept) begin
        if (is_prefix) begin
          payload <= INST[11:0];
          state   <= PREFIXED;
        end else begin
          IMM       <= next_imm;
          OPCODE    <= INST[15:12];
          OUT_VALID <= 1'b1;
          state     <= IDLE;
        end
      end
    end
  end

`ifdef IMMSEQ_PREFIX_ERR_EN
  // Sticky: only RESET clears it; FLUSH leaves it alone.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ERR <= 1'b0;
    end else if (accept && is_prefix && (state == PREFIXED)) begin
      ERR <= 1'b1;
    end
  end
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_imm_extend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_imm_extend_sequencer
//
// Directed scenarios with hand-derived expected values, followed by random
// traffic compared cycle by cycle against a behavioural model that derives
// results from the instruction-stream rules using integer arithmetic.
// -----------------------------------------------------------------------------
module tb_imm_extend_sequencer;

  localparam int W = 32;
`ifdef IMMSEQ_PREFIX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          FLUSH = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [15:0]   INST = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b1;
  logic [W-1:0]  IMM;
  logic [3:0]    OPCODE;
  logic          ERR;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state.
  bit            m_valid = 1'b0;
  logic [W-1:0]  m_imm = '0;
  logic [3:0]    m_op = '0;
  bit            m_err = 1'b0;
  bit            m_held = 1'b0;
  int            m_payload = 0;

  imm_extend_sequencer #(.OUTPUTSize(W)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .INST      (INST),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .IMM       (IMM),
    .OPCODE    (OPCODE),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Extend an unsigned field of 'bits' width: signed interpretation unless u.
  function automatic longint ext(input longint field, input int bits, input bit u);
    longint v;
    v = field;
    if (!u && (((field >> (bits - 1)) & 1) == 1)) v = v - (longint'(1) << bits);
    return v;
  endfunction

  // Advance the model by one clock using the inputs currently driven, then
  // let the DUT take the same edge and settle.
  task automatic advance();
    bit rdy;
    longint field;
    bit [63:0] wide;
    rdy = (!m_valid || OUT_READY) && !FLUSH;
    if (RESET) begin
      m_valid = 0; m_imm = '0; m_op = '0; m_err = 0; m_held = 0; m_payload = 0;
    end else if (FLUSH) begin
      m_valid = 0; m_held = 0;
    end else begin
      if (m_valid && OUT_READY) m_valid = 0;
      if (IN_VALID && rdy) begin
        if (INST[15:12] == 4'hF) begin
          if (m_held && ERR_EN) m_err = 1;
          m_held = 1;
          m_payload = int'(INST[11:0]);
        end else begin
          if (m_held) field = longint'(m_payload) * 256 + longint'(INST[7:0]);
          else        field = longint'(INST[7:0]);
          wide = 64'(ext(field, m_held ? 20 : 8, INST[8]));
          m_imm = wide[W-1:0];
          m_op = INST[15:12];
          m_valid = 1;
          m_held = 0;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    IN_VALID = 1'b1;
    INST = w;
    advance();
    IN_VALID = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    IN_VALID = 1'b1;
    INST = 16'h1280;
    OUT_READY = 1'b1;
    advance();
    advance();
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", IN_READY); end
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", OUT_VALID); end
    n_cmp++; if (IMM !== 32'h0) begin n_bad++; $display("FAIL reset_imm got %h want 0", IMM); end
    n_cmp++; if (OPCODE !== 4'h0) begin n_bad++; $display("FAIL reset_opcode got %h want 0", OPCODE); end
    n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", ERR); end
    RESET = 1'b0;
    IN_VALID = 1'b0;
    advance();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL reset_no_accept got %b want 0", OUT_VALID); end
  endtask

  task automatic test_short();
    send(16'h1280);
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_bad++; $display("FAIL short_valid got %b want 1", OUT_VALID); end
    n_cmp++; if (IMM !== 32'hFFFFFF80) begin n_bad++; $display("FAIL short_sext got %h want ffffff80", IMM); end
    n_cmp++; if (OPCODE !== 4'h1) begin n_bad++; $display("FAIL short_opcode got %h want 1", OPCODE); end
    send(16'h1380);
    n_cmp++; if (IMM !== 32'h00000080) begin n_bad++; $display("FAIL short_zext got %h want 00000080", IMM); end
  endtask

  task automatic test_long();
    send(16'hF800);
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL prefix_no_output got %b want 0", OUT_VALID); end
    send(16'h2005);
    n_cmp++; if (IMM !== 32'hFFF80005) begin n_bad++; $display("FAIL long_sext got %h want fff80005", IMM); end
    n_cmp++; if (OPCODE !== 4'h2) begin n_bad++; $display("FAIL long_opcode got %h want 2", OPCODE); end
    send(16'hF800);
    send(16'h2105);
    n_cmp++; if (IMM !== 32'h00080005) begin n_bad++; $display("FAIL long_zext got %h want 00080005", IMM); end
  endtask

  task automatic test_prefix_err();
    send(16'hF001);
    send(16'hF002);
    send(16'h1003);
    n_cmp++; if (IMM !== 32'h00000203) begin n_bad++; $display("FAIL dbl_prefix_imm got %h want 00000203", IMM); end
    n_cmp++; if (ERR !== ERR_EN) begin n_bad++; $display("FAIL dbl_prefix_err got %b want %b", ERR, ERR_EN); end
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    INST = 16'h1380;
    #1;
    n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %b want 0", IN_READY); end
    for (int i = 0; i < 3; i++) begin
      advance();
      n_cmp++; if (OUT_VALID !== 1'b1 || IMM !== 32'h00000203) begin
        n_bad++; $display("FAIL stall_hold got v=%b imm=%h want v=1 imm=00000203", OUT_VALID, IMM);
      end
    end
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      INST = 16'h4000 | 16'(i);
      #1;
      n_cmp++; if (IN_READY !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d] got %b want 1", i, IN_READY); end
      advance();
      n_cmp++; if (OUT_VALID !== 1'b1 || IMM !== W'(i) || OPCODE !== 4'h4) begin
        n_bad++; $display("FAIL b2b_result[%0d] got v=%b imm=%h op=%h want v=1 imm=%h op=4", i, OUT_VALID, IMM, OPCODE, i);
      end
    end
    IN_VALID = 1'b0;
    advance();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b want 0", OUT_VALID); end
  endtask

  task automatic test_flush();
    logic saved_err;
    saved_err = ERR;
    send(16'hF800);
    FLUSH = 1'b1;
    IN_VALID = 1'b1;
    INST = 16'h1005;
    #1;
    n_cmp++; if (IN_READY !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", IN_READY); end
    advance();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", OUT_VALID); end
    n_cmp++; if (ERR !== saved_err) begin n_bad++; $display("FAIL flush_err got %b want %b", ERR, saved_err); end
    send(16'h1280);
    n_cmp++; if (IMM !== 32'hFFFFFF80) begin n_bad++; $display("FAIL flush_short got %h want ffffff80", IMM); end
    // Same scenario with RESET discarding the held prefix.
    send(16'hF800);
    RESET = 1'b1;
    advance();
    RESET = 1'b0;
    send(16'h1280);
    n_cmp++; if (IMM !== 32'hFFFFFF80 || OUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL reset_short got v=%b imm=%h want v=1 imm=ffffff80", OUT_VALID, IMM);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int c = 0; c < 3000; c++) begin
      op = ($urandom_range(0, 99) < 30) ? 4'hF : 4'($urandom_range(0, 14));
      INST      = {op, 12'($urandom)};
      IN_VALID  = ($urandom_range(0, 99) < 70);
      OUT_READY = ($urandom_range(0, 99) < 65);
      FLUSH     = ($urandom_range(0, 99) < 3);
      RESET     = ($urandom_range(0, 199) < 1);
      #1;
      n_cmp++; if (IN_READY !== ((!m_valid || OUT_READY) && !FLUSH)) begin
        n_bad++; $display("FAIL rnd_in_ready[%0d] got %b want %b", c, IN_READY, (!m_valid || OUT_READY) && !FLUSH);
      end
      advance();
      n_cmp++; if (OUT_VALID !== m_valid) begin
        n_bad++; $display("FAIL rnd_valid[%0d] got %b want %b", c, OUT_VALID, m_valid);
      end
      if (m_valid) begin
        n_cmp++; if (IMM !== m_imm || OPCODE !== m_op) begin
          n_bad++; $display("FAIL rnd_result[%0d] got imm=%h op=%h want imm=%h op=%h", c, IMM, OPCODE, m_imm, m_op);
        end
      end
      n_cmp++; if (ERR !== m_err) begin
        n_bad++; $display("FAIL rnd_err[%0d] got %b want %b", c, ERR, m_err);
      end
    end
    FLUSH = 1'b0;
    RESET = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_short();
    test_long();
    test_prefix_err();
    test_back_to_back();
    test_flush();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
